// File: rtl/mips32_regfile_sb.sv
// MIPS32 register file with a RAW/WAW pending-write scoreboard, write-through
// bypass on the read ports and a halt/drain FSM that stops issue until writebacks land.
module mips32_regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk_1,
    input  logic                rst,
    input  logic                iss_valid,
    output logic                iss_ready,
    input  logic [NRD*AW-1:0]   iss_rs,
    input  logic [NRD-1:0]      iss_rs_en,
    input  logic [AW-1:0]       iss_rd,
    input  logic                iss_rd_en,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                hlt_req,
    input  logic                resume,
    output logic                halted,
    output logic [AW:0]         out_cnt,
    output logic                wb_err
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [XLEN-1:0]   rf_r [NREGS];
    logic [NREGS-1:0]  pend_r, pend_nxt_s, pend_eff_s, wb_mask_s, set_mask_s;
    logic [AW:0]       cnt_r, cnt_nxt_s;
    logic              err_r, halted_r;
    logic              hazard_s, ready_s, fire_s, set_s, clr_s;

    function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
        logic [AW:0] n;
        n = '0;
        for (int i = 0; i < NREGS; i++) begin
            n = n + (AW+1)'(v[i]);
        end
        return n;
    endfunction

    // Hazard detection and next scoreboard contents; a same-cycle set beats a clear.
    always_comb begin
        wb_mask_s  = '0;
        set_mask_s = '0;
        clr_s      = wb_valid & (wb_rd != AW'(0));
        if (clr_s) begin
            wb_mask_s[wb_rd] = 1'b1;
        end else begin
            wb_mask_s = '0;
        end
        pend_eff_s = pend_r & ~wb_mask_s;
        hazard_s   = iss_rd_en & (iss_rd != AW'(0)) & pend_eff_s[iss_rd];
        for (int i = 0; i < NRD; i++) begin
            hazard_s = hazard_s | (iss_rs_en[i] & pend_eff_s[iss_rs[i*AW +: AW]]);
        end
        ready_s = (state_r == ST_RUN) & ~hazard_s;
        fire_s  = iss_valid & ready_s;
        set_s   = fire_s & iss_rd_en & (iss_rd != AW'(0));
        if (set_s) begin
            set_mask_s[iss_rd] = 1'b1;
        end else begin
            set_mask_s = '0;
        end
        pend_nxt_s = (pend_r & ~wb_mask_s) | set_mask_s;
        cnt_nxt_s  = popcount(pend_nxt_s);
    end

    // Operand read with R0 hardwired to zero and writeback bypass.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            if (iss_rs[i*AW +: AW] == AW'(0)) begin
                rd_data[i*XLEN +: XLEN] = '0;
            end else if (wb_valid && (wb_rd == iss_rs[i*AW +: AW])) begin
                rd_data[i*XLEN +: XLEN] = wb_data;
            end else begin
                rd_data[i*XLEN +: XLEN] = rf_r[iss_rs[i*AW +: AW]];
            end
        end
    end

    // Halt/drain next-state logic; DRAIN exits once the scoreboard empties.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN:    state_nxt_s = hlt_req ? ST_DRAIN : ST_RUN;
            ST_DRAIN:  state_nxt_s = (cnt_nxt_s == (AW+1)'(0)) ? ST_HALTED : ST_DRAIN;
            ST_HALTED: state_nxt_s = resume ? ST_RUN : ST_HALTED;
            default:   state_nxt_s = ST_RUN;
        endcase
    end

    // Register array write port.
    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                rf_r[r] <= '0;
            end
        end else if (clr_s) begin
            rf_r[wb_rd] <= wb_data;
        end
    end

    // Scoreboard, pending count, error flag and FSM state.
    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            pend_r   <= '0;
            cnt_r    <= '0;
            err_r    <= 1'b0;
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
        end else begin
            pend_r   <= pend_nxt_s;
            cnt_r    <= cnt_nxt_s;
            err_r    <= err_r | (clr_s & ~pend_r[wb_rd]);
            state_r  <= state_nxt_s;
            halted_r <= (state_nxt_s == ST_HALTED);
        end
    end

    assign iss_ready = ready_s;
    assign halted    = halted_r;
    assign out_cnt   = cnt_r;
    assign wb_err    = err_r;

endmodule

// File: tb/tb_mips32_regfile_sb.sv
// Scoreboard bench for mips32_regfile_sb: directed hazard/halt scenarios then random
// traffic, checked against an array-based reference model of the register file.
module tb_mips32_regfile_sb;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk_1 = 1'b1;
    logic            rst;
    logic            iss_valid, iss_ready, iss_rd_en;
    logic [2*AW-1:0] iss_rs;
    logic [1:0]      iss_rs_en;
    logic [AW-1:0]   iss_rd, wb_rd;
    logic [63:0]     rd_data;
    logic            wb_valid, hlt_req, resume, halted, wb_err;
    logic [31:0]     wb_data;
    logic [AW:0]     out_cnt;

    always #5 clk_1 = ~clk_1;

    mips32_regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2)) dut (
        .clk_1(clk_1), .rst(rst),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rs(iss_rs), .iss_rs_en(iss_rs_en),
        .iss_rd(iss_rd), .iss_rd_en(iss_rd_en),
        .rd_data(rd_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .hlt_req(hlt_req), .resume(resume),
        .halted(halted), .out_cnt(out_cnt), .wb_err(wb_err)
    );

    typedef struct {
        logic        ready;
        logic [31:0] d0, d1;
        logic [5:0]  cnt;
        logic        halted, err;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;

    // reference model: state 0=run, 1=drain, 2=halted
    logic [31:0] m_rf[32];
    bit          m_pend[32];
    int          m_state;
    bit          m_err;

    task automatic m_reset();
        for (int r = 0; r < 32; r++) begin
            m_rf[r] = 32'd0;
            m_pend[r] = 1'b0;
        end
        m_state = 0;
        m_err = 1'b0;
    endtask

    function automatic int m_count();
        int n = 0;
        for (int r = 0; r < 32; r++) n += int'(m_pend[r]);
        return n;
    endfunction

    function automatic bit m_busy(input logic [4:0] r);
        return m_pend[r] && !(wb_valid && wb_rd == r);
    endfunction

    function automatic bit m_ready();
        bit haz;
        haz = iss_rd_en && (iss_rd != 5'd0) && m_busy(iss_rd);
        if (iss_rs_en[0] && m_busy(iss_rs[4:0])) haz = 1'b1;
        if (iss_rs_en[1] && m_busy(iss_rs[9:5])) haz = 1'b1;
        return (m_state == 0) && !haz;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] rs);
        if (rs == 5'd0) return 32'd0;
        if (wb_valid && wb_rd == rs) return wb_data;
        return m_rf[rs];
    endfunction

    task automatic m_update(input bit fire);
        if (wb_valid && wb_rd != 5'd0) begin
            if (!m_pend[wb_rd]) m_err = 1'b1;
            m_rf[wb_rd] = wb_data;
            m_pend[wb_rd] = 1'b0;
        end
        if (fire && iss_rd_en && iss_rd != 5'd0) m_pend[iss_rd] = 1'b1;
        case (m_state)
            0: if (hlt_req) m_state = 1;
            1: if (m_count() == 0) m_state = 2;
            2: if (resume) m_state = 0;
            default: m_state = 0;
        endcase
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // monitor: one expected record per cycle, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("iss_ready", 64'(iss_ready), 64'(e.ready));
                chk("rd_data0", 64'(rd_data[31:0]), 64'(e.d0));
                chk("rd_data1", 64'(rd_data[63:32]), 64'(e.d1));
                chk("out_cnt", 64'(out_cnt), 64'(e.cnt));
                chk("halted", 64'(halted), 64'(e.halted));
                chk("wb_err", 64'(wb_err), 64'(e.err));
            end
        end
    end

    task automatic step();
        exp_t e;
        bit fire;
        if (!rst) m_reset();
        e.ready  = m_ready();
        e.d0     = m_read(iss_rs[4:0]);
        e.d1     = m_read(iss_rs[9:5]);
        e.cnt    = 6'(m_count());
        e.halted = (m_state == 2);
        e.err    = m_err;
        q.push_back(e);
        fire = iss_valid && e.ready;
        @(posedge clk_1);
        if (rst) m_update(fire);
        else m_reset();
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_rs = '0; iss_rs_en = 2'b00; iss_rd = '0; iss_rd_en = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = 32'd0; hlt_req = 1'b0; resume = 1'b0;
    endtask

    task automatic set_iss(input bit v, input logic [4:0] rs0, input logic [4:0] rs1,
                           input logic [1:0] en, input logic [4:0] rd, input bit rden);
        iss_valid = v; iss_rs = {rs1, rs0}; iss_rs_en = en; iss_rd = rd; iss_rd_en = rden;
    endtask

    task automatic set_wb(input bit v, input logic [4:0] rd, input logic [31:0] d);
        wb_valid = v; wb_rd = rd; wb_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1);
    end

    initial begin
        logic [4:0] pick;
        int start;
        idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
        idle(); step();

        // back-to-back RAW on r1, released by its writeback
        idle(); set_iss(1'b1, 5'd0, 5'd0, 2'b00, 5'd1, 1'b1); step();
        idle(); set_iss(1'b1, 5'd1, 5'd0, 2'b01, 5'd0, 1'b0); step(); step();
        set_wb(1'b1, 5'd1, 32'd10); step();

        // independent ops, then ADD r1,r2
        for (int i = 1; i <= 3; i++) begin
            idle(); set_iss(1'b1, 5'd0, 5'd0, 2'b00, 5'(i), 1'b1); step();
        end
        idle(); set_wb(1'b1, 5'd1, 32'd10); step();
        idle(); set_wb(1'b1, 5'd2, 32'd20); step();
        idle(); set_wb(1'b1, 5'd3, 32'd25); step();
        idle(); set_iss(1'b1, 5'd1, 5'd2, 2'b11, 5'd4, 1'b0); step();

        // WAW on r5 with a coincident writeback
        idle(); set_iss(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1); step();
        set_wb(1'b1, 5'd5, 32'h55); step();
        idle(); step();
        set_wb(1'b1, 5'd5, 32'h66); step();

        // R0 destination and writeback
        idle(); set_iss(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1); step();
        idle(); set_iss(1'b0, 5'd0, 5'd0, 2'b01, 5'd0, 1'b0); set_wb(1'b1, 5'd0, 32'd7); step();

        // halt with two writes pending, then resume
        idle(); set_iss(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1); step();
        idle(); set_iss(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1); step();
        idle(); hlt_req = 1'b1; step();
        idle(); set_iss(1'b1, 5'd0, 5'd0, 2'b00, 5'd8, 1'b1); step();
        idle(); set_wb(1'b1, 5'd6, 32'h600); step();
        idle(); set_wb(1'b1, 5'd7, 32'h700); step();
        idle(); step();
        resume = 1'b1; step();
        idle(); step();

        // stray writeback, then reset in the middle of a drain
        idle(); set_wb(1'b1, 5'd9, 32'h99); step();
        idle(); set_iss(1'b0, 5'd9, 5'd6, 2'b11, 5'd0, 1'b0); step();
        idle(); set_iss(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1); step();
        idle(); hlt_req = 1'b1; step();
        idle(); set_iss(1'b0, 5'd9, 5'd6, 2'b11, 5'd0, 1'b0); rst = 1'b0; step(); step();
        rst = 1'b1; step();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            idle();
            set_iss(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    2'($urandom), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                pick = 5'($urandom_range(0, 7));
                start = $urandom_range(0, 31);
                for (int k = 0; k < 32; k++) begin
                    if (m_pend[(start + k) % 32]) pick = 5'((start + k) % 32);
                end
                set_wb(1'b1, pick, $urandom);
            end
            hlt_req = ($urandom_range(0, 19) == 0);
            resume  = ($urandom_range(0, 3) == 0);
            step();
        end

        idle(); step();
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
